// File: rtl/av2_recon_packer_if.sv
// Pixel-in / packed-word-out streams of the reconstruction packer.
// The slave modport is the packer's view; master is the producer/sink side.
interface av2_recon_packer_if #(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned DW          = 128,
    parameter int unsigned ADDR_WIDTH  = 32
);
    logic [PIXEL_WIDTH-1:0] pix_data;
    logic                   pix_valid;
    logic                   pix_ready;
    logic [DW-1:0]          out_data;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output pix_data, pix_valid, out_ready,
        input  pix_ready, out_data, out_addr, out_valid
    );

    modport slave (
        input  pix_data, pix_valid, out_ready,
        output pix_ready, out_data, out_addr, out_valid
    );
endinterface

// File: rtl/av2_recon_packer.sv
// Packs a raster pixel stream into LANES-wide words with per-row end padding and
// sequential word addresses, buffered through a small first-word-fall-through FIFO.
module av2_recon_packer #(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned LANES       = 16,
    parameter int unsigned OUT_8BIT    = 1,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    localparam int unsigned OW         = (OUT_8BIT != 0) ? 8 : PIXEL_WIDTH,
    localparam int unsigned DW         = LANES * OW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [15:0]           frame_width_i,
    input  logic [15:0]           frame_height_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    av2_recon_packer_if.slave     bus,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_overrun_o
);
    localparam int unsigned LaneBits = $clog2(LANES);
    localparam int unsigned PtrBits  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntBits  = PtrBits + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [15:0]           col_q, col_d;
    logic [15:0]           row_q, row_d;
    logic [ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]           width_q, width_d;
    logic [15:0]           height_q, height_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DW-1:0]         word_q, word_d;
    logic                  err_q, err_d;

    logic [DW-1:0]         mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr [FIFO_DEPTH];
    logic [PtrBits-1:0]    wptr_q, wptr_d;
    logic [PtrBits-1:0]    rptr_q, rptr_d;
    logic [CntBits-1:0]    count_q, count_d;

    logic [OW-1:0]         pix_conv;
    logic [DW-1:0]         packed_word;
    logic [LaneBits-1:0]   lane;
    logic                  empty_frame;
    logic                  start_accept;
    logic                  pix_fire;
    logic                  pix_accept;
    logic                  row_end;
    logic                  frame_end;
    logic                  push;
    logic                  pop;

    // Round-half-up to 8 bits, saturating when the rounding carries past 255.
    if (OUT_8BIT != 0 && PIXEL_WIDTH > 8) begin : g_round
        localparam int unsigned Shift = PIXEL_WIDTH - 8;
        localparam logic [PIXEL_WIDTH:0] Half = (PIXEL_WIDTH + 1)'(1) << (Shift - 1);
        logic [PIXEL_WIDTH:0] sum;
        logic [PIXEL_WIDTH:0] shifted;
        assign sum      = {1'b0, bus.pix_data} + Half;
        assign shifted  = sum >> Shift;
        assign pix_conv = (|shifted[PIXEL_WIDTH:8]) ? 8'hFF : shifted[7:0];
    end else begin : g_native
        assign pix_conv = bus.pix_data;
    end

    assign lane         = col_q[LaneBits-1:0];
    assign empty_frame  = (width_q == 16'd0) || (height_q == 16'd0);
    assign start_accept = start_i && (state_q == StIdle);
    assign pix_fire     = bus.pix_valid && bus.pix_ready;
    assign pix_accept   = pix_fire && !empty_frame;
    assign row_end      = (col_q == width_q - 16'd1);
    assign frame_end    = row_end && (row_q == height_q - 16'd1);
    assign push         = pix_accept && ((&lane) || row_end);
    assign pop          = bus.out_valid && bus.out_ready;

    // Lanes below the current one keep earlier pixels; at row end the rest replicate.
    always_comb begin
        packed_word = word_q;
        for (int unsigned i = 0; i < LANES; i++) begin
            if ((LaneBits'(i) == lane) || (row_end && (LaneBits'(i) > lane))) begin
                packed_word[i*OW +: OW] = pix_conv;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = start_i && ((state_q == StRun) || (state_q == StDrain));
        unique case (state_q)
            StIdle: if (start_i) state_d = StRun;
            StRun: begin
                if (empty_frame) begin
                    state_d = StDone;
                end else if (pix_accept && frame_end) begin
                    state_d = StDrain;
                end
            end
            StDrain: if (count_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        word_cnt_d = word_cnt_q;
        width_d    = width_q;
        height_d   = height_q;
        base_d     = base_q;
        word_d     = word_q;
        if (start_accept) begin
            width_d    = frame_width_i;
            height_d   = frame_height_i;
            base_d     = base_addr_i;
            col_d      = '0;
            row_d      = '0;
            word_cnt_d = '0;
        end
        if (pix_accept) begin
            word_d = packed_word;
            if (row_end) begin
                col_d = '0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
        if (push) word_cnt_d = word_cnt_q + 1'b1;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            word_cnt_q <= '0;
            width_q    <= '0;
            height_q   <= '0;
            base_q     <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            word_cnt_q <= word_cnt_d;
            width_q    <= width_d;
            height_q   <= height_d;
            base_q     <= base_d;
            word_q     <= word_d;
            err_q      <= err_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q] <= packed_word;
            mem_addr[wptr_q] <= base_q + word_cnt_q;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = bus.out_valid ? mem_data[rptr_q] : '0;
    assign bus.out_addr  = bus.out_valid ? mem_addr[rptr_q] : '0;
    assign bus.pix_ready = (state_q == StRun) && (count_q < CntBits'(FIFO_DEPTH));

    assign busy_o        = (state_q == StRun) || (state_q == StDrain);
    assign frame_done_o  = (state_q == StDone);
    assign err_overrun_o = err_q;
endmodule

// File: tb/tb_av2_recon_packer.sv
// Randomised and directed frames against a queue-based word model of the packer;
// a second instance covers native-width (OUT_8BIT=0) packing.
module tb_av2_recon_packer;
    localparam int PW    = 10;
    localparam int LANES = 16;

    typedef struct {
        logic [127:0] data;
        logic [31:0]  addr;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start, start_n;
    logic [15:0] fw, fh;
    logic [31:0] base;
    logic        busy, frame_done, err_overrun;
    logic        busy_n, frame_done_n, err_overrun_n;

    int           n_checks = 0;
    int           n_fail = 0;
    int           done_seen = 0;
    int           ready_mode = 1;
    bit           valid_rand = 1'b0;
    bit           abort = 1'b0;
    int unsigned  pix_mem[];
    word_t        exp_q[$];
    logic [127:0] got_data[$];
    logic [31:0]  got_addr[$];
    bit           stall_prev = 1'b0;
    logic [127:0] prev_data;
    logic [31:0]  prev_addr;

    always #5 clk = ~clk;

    av2_recon_packer_if #(.PIXEL_WIDTH(10), .DW(128), .ADDR_WIDTH(32)) bus ();
    av2_recon_packer_if #(.PIXEL_WIDTH(10), .DW(40), .ADDR_WIDTH(32)) bus_n ();

    av2_recon_packer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start),
        .frame_width_i (fw),
        .frame_height_i(fh),
        .base_addr_i   (base),
        .bus           (bus),
        .busy_o        (busy),
        .frame_done_o  (frame_done),
        .err_overrun_o (err_overrun)
    );

    av2_recon_packer #(.PIXEL_WIDTH(10), .LANES(4), .OUT_8BIT(0), .FIFO_DEPTH(2)) u_dut_n (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_n),
        .frame_width_i (fw),
        .frame_height_i(fh),
        .base_addr_i   (base),
        .bus           (bus_n),
        .busy_o        (busy_n),
        .frame_done_o  (frame_done_n),
        .err_overrun_o (err_overrun_n)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] conv(input int unsigned p);
        int unsigned v;
        v = (p + (1 << (PW - 9))) >> (PW - 8);
        return (v > 255) ? 8'd255 : v[7:0];
    endfunction

    function automatic int unsigned pixel_of(input int mode, input int x, input int y);
        case (mode)
            0:       return (x + y) & 1023;
            1:       return $urandom_range(0, 1023);
            2:       return (x * 50 + y * 7) & 1023;
            default: return (x == 0) ? 1023 : (x == 1) ? 514 : 1;
        endcase
    endfunction

    // Expected words straight from the frame: ceil(w/LANES) per row, tail padded with x=w-1.
    task automatic build_model(input int w, input int h, input logic [31:0] b, input int mode);
        int j = 0;
        pix_mem = new[w * h];
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) pix_mem[y*w + x] = pixel_of(mode, x, y);
        for (int y = 0; y < h; y++) begin
            for (int wd = 0; wd * LANES < w; wd++) begin
                word_t e;
                e.data = '0;
                for (int l = 0; l < LANES; l++) begin
                    int k = wd * LANES + l;
                    if (k >= w) k = w - 1;
                    e.data[l*8 +: 8] = conv(pix_mem[y*w + k]);
                end
                e.addr = b + 32'(j);
                exp_q.push_back(e);
                j++;
            end
        end
    endtask

    task automatic start_frame(input int w, input int h, input logic [31:0] b, input int mode);
        build_model(w, h, b, mode);
        got_data.delete();
        got_addr.delete();
        done_seen = 0;
        @(posedge clk); #1;
        fw = 16'(w); fh = 16'(h); base = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_pixels(input int n);
        int  idx = 0;
        int  cyc = 0;
        bit  fire;
        while (idx < n && !abort && cyc < 20000) begin
            bus.pix_valid = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.pix_data  = 10'(pix_mem[idx]);
            @(negedge clk);
            fire = bus.pix_valid && bus.pix_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
        end
        bus.pix_valid = 1'b0;
        if (!abort) check_int("pixels_sent", idx, n);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (done_seen == 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check_int("frame_done_once", done_seen, 1);
        check("busy_after", busy, 1'b0);
        check_int("model_drained", exp_q.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Scoreboard: every accepted word against the model; held words must not change.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (stall_prev) begin
                check("hold_data", bus.out_data, prev_data);
                check("hold_addr", bus.out_addr, prev_addr);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL word_extra: got %0h at %0h, required no word",
                             bus.out_data, bus.out_addr);
                end else begin
                    word_t e;
                    e = exp_q.pop_front();
                    check("word_data", bus.out_data, e.data);
                    check("word_addr", bus.out_addr, e.addr);
                end
                got_data.push_back(bus.out_data);
                got_addr.push_back(bus.out_addr);
            end
            if (frame_done) done_seen++;
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_addr  = bus.out_addr;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        bit          fire;
        logic [39:0] word_n;
        logic [31:0] addr_n;
        int unsigned nv[3] = '{1023, 514, 1};

        start = 1'b0; start_n = 1'b0; fw = '0; fh = '0; base = '0;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.out_ready = 1'b1;
        bus_n.pix_valid = 1'b0; bus_n.pix_data = '0; bus_n.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_pix_ready", bus.pix_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_out_addr", bus.out_addr, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err_overrun, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // 64x64 diagonal ramp, sink always ready.
        ready_mode = 1; valid_rand = 1'b0;
        start_frame(64, 64, 32'h1000, 0);
        drive_pixels(4096);
        wait_done();
        check_int("ramp_words", got_data.size(), 256);
        check("ramp_first_word", got_data[0], 128'h04040303030302020202010101010000);
        check("ramp_first_addr", got_addr[0], 32'h1000);
        check("ramp_last_addr", got_addr[got_addr.size()-1], 32'h10FF);

        // 20-wide rows: second word of each row is padded with x=19.
        ready_mode = 2; valid_rand = 1'b1;
        start_frame(20, 2, 32'h200, 2);
        drive_pixels(40);
        wait_done();
        check_int("pad_words", got_data.size(), 4);
        check("pad_row0", got_data[1][127:32], {12{8'd238}});
        check("pad_row1", got_data[3][127:32], {12{8'd239}});

        // Rounding corners through the 8-bit path.
        start_frame(3, 1, 32'h300, 3);
        drive_pixels(3);
        wait_done();
        check("round_word", got_data[0], 128'h81FF);

        // Long sink stall: intake must stop once the FIFO is full, nothing lost.
        ready_mode = 0; valid_rand = 1'b0;
        start_frame(64, 4, 32'h400, 1);
        fork
            drive_pixels(256);
            begin
                repeat (200) @(negedge clk);
                check("stall_pix_ready", bus.pix_ready, 1'b0);
                check("stall_out_valid", bus.out_valid, 1'b1);
                check_int("stall_no_words", got_data.size(), 0);
                ready_mode = 2;
            end
        join
        wait_done();
        check_int("stall_words", got_data.size(), 16);

        // Start while busy: error pulse, frame carries on untouched.
        ready_mode = 1; valid_rand = 1'b1;
        start_frame(32, 8, 32'h500, 1);
        fork
            drive_pixels(256);
            begin
                repeat (20) @(posedge clk);
                #1 start = 1'b1; fw = 16'd5; fh = 16'd5; base = 32'h0;
                @(posedge clk); #1 start = 1'b0;
                @(negedge clk);
                check("ovr_pulse", err_overrun, 1'b1);
                check("ovr_busy", busy, 1'b1);
                @(negedge clk);
                check("ovr_one_cycle", err_overrun, 1'b0);
            end
        join
        wait_done();
        check_int("ovr_words", got_data.size(), 16);

        // Empty frames: frame_done two cycles after start, no words.
        for (int z = 0; z < 2; z++) begin
            @(posedge clk); #1;
            fw = (z == 0) ? 16'd0 : 16'd7; fh = (z == 0) ? 16'd5 : 16'd0; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check("empty_done_n1", frame_done, 1'b0);
            check("empty_busy_n1", busy, 1'b1);
            @(negedge clk);
            check("empty_done_n2", frame_done, 1'b1);
            @(negedge clk);
            check("empty_done_n3", frame_done, 1'b0);
            check("empty_busy_n3", busy, 1'b0);
        end

        // Random frames and bases (first one wraps the address space).
        ready_mode = 2; valid_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            int w = $urandom_range(1, 40);
            int h = $urandom_range(1, 4);
            start_frame(w, h, (r == 0) ? 32'hFFFF_FFFE : $urandom, 1);
            drive_pixels(w * h);
            wait_done();
            check_int("rand_words", got_data.size(), h * ((w + LANES - 1) / LANES));
        end

        // Reset mid-frame, then a fresh 32x32 frame.
        ready_mode = 1; valid_rand = 1'b0;
        start_frame(64, 64, 32'h2000, 0);
        fork
            drive_pixels(4096);
            begin
                cyc = 0;
                while (got_data.size() < 100 && cyc < 10000) begin
                    @(negedge clk);
                    cyc++;
                end
                check_int("mid_words_reached", got_data.size(), 100);
                @(posedge clk); #1 rst_n = 1'b1; abort = 1'b1;
            end
        join
        @(negedge clk);
        check("mid_rst_pix_ready", bus.pix_ready, 1'b0);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_out_data", bus.out_data, 128'd0);
        check("mid_rst_out_addr", bus.out_addr, 32'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", frame_done, 1'b0);
        check("mid_rst_err", err_overrun, 1'b0);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_out_valid", bus.out_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        start_frame(32, 32, 32'h3000, 1);
        drive_pixels(1024);
        wait_done();
        check_int("post_rst_words", got_data.size(), 64);
        check("post_rst_first_addr", got_addr[0], 32'h3000);

        // Native 10-bit lanes on the 4-lane instance.
        @(posedge clk); #1;
        fw = 16'd3; fh = 16'd1; base = 32'h77; start_n = 1'b1;
        @(posedge clk); #1 start_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            fire = 1'b0;
            while (!fire && cyc < 50) begin
                bus_n.pix_valid = 1'b1;
                bus_n.pix_data  = 10'(nv[i]);
                @(negedge clk);
                fire = bus_n.pix_ready;
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus_n.pix_valid = 1'b0;
        word_n = '0;
        addr_n = '0;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            if (bus_n.out_valid) begin
                word_n = bus_n.out_data;
                addr_n = bus_n.out_addr;
                cyc = 50;
            end
            cyc++;
        end
        check("native_word", word_n, {10'd1, 10'd1, 10'd514, 10'd1023});
        check("native_addr", addr_n, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/av2_recon_packer.md
AV2_RECON_PACKER -- requirements
Module: av2_recon_packer

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 10, meaning input pixel bit depth (8..12).
REQ-002 SHALL have parameter LANES, default 16, meaning pixels per output word (power of two, 2..32).
REQ-003 SHALL have parameter OUT_8BIT, default 1; 1 = pixels rounded to 8 bits, 0 = native PIXEL_WIDTH.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning output word FIFO entries (power of two, 2..16).
REQ-005 SHALL have parameter ADDR_WIDTH, default 32, meaning output address width.
REQ-006 SHALL define OW = OUT_8BIT ? 8 : PIXEL_WIDTH and DW = LANES*OW.
REQ-007 clk  input  1  clock, all logic on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-high.
REQ-009 start  input  1  one-cycle pulse, latches frame parameters, begins frame.
REQ-010 frame_width  input  16  pixels per row.
REQ-011 frame_height  input  16  rows per frame.
REQ-012 base_addr  input  ADDR_WIDTH  word address of first output word.
REQ-013 pix_data / pix_valid / pix_ready  input PIXEL_WIDTH / input 1 / output 1  raster-order pixel stream.
REQ-014 out_data / out_addr / out_valid / out_ready  output DW / output ADDR_WIDTH / output 1 / input 1  packed word stream.
REQ-015 busy  output  1  high from accepted start until frame_done.
REQ-016 frame_done  output  1  one-cycle pulse at frame completion.
REQ-017 err_overrun  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-018 States IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN after last pixel of frame accepted; DRAIN->DONE when FIFO empty and last word accepted by sink; DONE->IDLE unconditionally next cycle.
REQ-019 frame_done SHALL be high exactly during DONE; busy high in RUN and DRAIN.
REQ-020 start in IDLE with frame_width==0 or frame_height==0 SHALL go RUN->DONE path without any word write; frame_done one cycle after the following cycle (start at cycle N, frame_done at N+2).
REQ-021 start while busy SHALL be ignored and pulse err_overrun the next cycle.
REQ-022 Pixel transfer occurs when pix_valid && pix_ready; pix_ready = (state==RUN) && (FIFO count < FIFO_DEPTH).
REQ-023 Pixel k of a row SHALL occupy lane (k mod LANES), lane 0 at out_data[OW-1:0].
REQ-024 A word SHALL be pushed to the FIFO in the same cycle its LANES-th pixel or the row's last pixel is accepted.
REQ-025 Partial end-of-row words SHALL replicate the row's last pixel into all unfilled higher lanes.
REQ-026 Words per row SHALL be ceil(frame_width/LANES); word j of frame SHALL carry out_addr = base_addr + j (modulo 2^ADDR_WIDTH).
REQ-027 OUT_8BIT=1 with PIXEL_WIDTH>8: value = min(255, (p + 2^(PIXEL_WIDTH-9)) >> (PIXEL_WIDTH-8)); PIXEL_WIDTH==8 passthrough.
REQ-028 FIFO SHALL be first-word-fall-through; out_valid = FIFO non-empty; out_data/out_addr stable while out_valid && !out_ready.
REQ-029 Simultaneous FIFO push and pop SHALL keep count unchanged; no word SHALL be lost or duplicated under any out_ready pattern.
REQ-030 Column, row and word counters SHALL be 16/16/ADDR_WIDTH bits, cleared on accepted start.

Reset
REQ-031 While rst_n asserted: state IDLE, FIFO empty, counters zero, pix_ready=0, out_valid=0, out_data=0, out_addr=0, busy=0, frame_done=0, err_overrun=0.
REQ-032 Reset mid-frame SHALL discard all buffered pixels/words; after release block waits for new start.

Verification
REQ-033 Defaults, 64x64, base_addr=0x1000, out_ready=1, pixel=(x+y)&1023 -> 256 words at 0x1000..0x10FF in order, frame_done once, busy low after.
REQ-034 frame_width=20, frame_height=2 -> 4 words; words 1 and 3 lanes 4..15 equal pixel x=19 of that row.
REQ-035 out_ready=0 for 200 cycles mid-frame -> pix_ready low after FIFO_DEPTH words queued; after release all words arrive, none lost.
REQ-036 PIXEL_WIDTH=10, OUT_8BIT=1: pixel 1023 -> 255, 514 -> 129, 1 -> 0; OUT_8BIT=0: 1023 -> 1023.
REQ-037 start pulse while busy -> err_overrun pulse next cycle, current frame output unchanged; frame_width=0 start -> no out_valid, frame_done at start+2.
REQ-038 rst_n asserted after 100 words of 64x64 frame -> all outputs at reset values; new 32x32 frame then yields 64 words from base_addr.
